// File: rtl/serial_subtractor_nbits_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the start request and operands; the slave returns status and results.
interface serial_subtractor_nbits_if #(
  parameter int N = 8
);
  logic         Start_in;
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic         Bor_in;
  logic         Busy_out;
  logic         Done_out;
  logic [N-1:0] D_out;
  logic         Bor_out;
  logic         Ovf_out;

  modport master (
    output Start_in, A_in, B_in, Bor_in,
    input  Busy_out, Done_out, D_out, Bor_out, Ovf_out
  );

  modport slave (
    input  Start_in, A_in, B_in, Bor_in,
    output Busy_out, Done_out, D_out, Bor_out, Ovf_out
  );
endinterface

// File: rtl/serial_subtractor_nbits.sv
// Bit-serial N-bit two's-complement subtractor, D = A - B - Bor_in.
// One full-subtractor bit per clock, LSB first, with a borrow flop carried
// between bits. Results are held until the next completion or reset.
module serial_subtractor_nbits #(
  parameter int N = 8
) (
  input  logic                        CLK_in,
  input  logic                        RST_in,
  serial_subtractor_nbits_if.slave    bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           busy;
  logic           done;

  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  // Holds the N-1 low result bits already produced; the MSB joins on the last step.
  logic [N-2:0]   d_sr;
  logic           bw;
  logic [CW-1:0]  cnt;
  logic           a_msb;
  logic           b_msb;

  logic [N-1:0]   d_q;
  logic           bor_q;
  logic           ovf_q;

  logic           d_bit;
  logic           w_nxt;
  logic [N-1:0]   sh;

  // Single-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic w);
    full_sub = {(~a & b) | (~(a ^ b) & w), a ^ b ^ w};
  endfunction

  // State register.
  always_ff @(posedge CLK_in) begin
    if (RST_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode; a start is only honoured in IDLE or DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start_in) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.Start_in) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current bit of the subtraction and the result word as it would look after this step.
  always_comb begin
    {w_nxt, d_bit} = full_sub(a_sr[0], b_sr[0], bw);
    sh             = {d_bit, d_sr};
  end

  // Operand shift registers, borrow flop, counter and held result registers.
  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      bw    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d_q   <= '0;
      bor_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.A_in;
      b_sr  <= bus.B_in;
      bw    <= bus.Bor_in;
      cnt   <= '0;
      a_msb <= bus.A_in[N-1];
      b_msb <= bus.B_in[N-1];
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      bw   <= w_nxt;
      d_sr <= sh[N-1:1];
      cnt  <= cnt + 1'b1;
      if (cnt == LAST) begin
        d_q   <= sh;
        bor_q <= w_nxt;
        ovf_q <= (a_msb != b_msb) & (d_bit != a_msb);
      end
    end
  end

  assign bus.Busy_out = busy;
  assign bus.Done_out = done;
  assign bus.D_out    = d_q;
  assign bus.Bor_out  = bor_q;
  assign bus.Ovf_out  = ovf_q;

endmodule

// File: doc/serial_subtractor_nbits.md
Name: serial_subtractor_nbits

Overview:
- Bit-serial N-bit two's-complement subtractor: D = A - B - Bor_in.
- Processes one bit per clock, LSB first, through a single registered full-subtractor stage and a borrow flip-flop.
- Counterpart to the ripple full-adder datapath. Used where area matters more than latency.
- Start/Busy/Done handshake; operands latched at start.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
CLK_in  input  1  system clock, rising edge
RST_in  input  1  synchronous reset, active-high
Start_in  input  1  start request; sampled only when accepted (IDLE or DONE)
A_in  input  N  minuend, latched on accepted start
B_in  input  N  subtrahend, latched on accepted start
Bor_in  input  1  borrow-in, latched on accepted start
Busy_out  output  1  high while a subtraction is in progress
Done_out  output  1  one-cycle pulse when result registers update
D_out  output  N  difference, held until next completion
Bor_out  output  1  final borrow (1 = unsigned A < B + Bor_in), held
Ovf_out  output  1  signed overflow flag, held

Behaviour:
- Reset:
  - Synchronous, active-high. Overrides every other input, including mid-operation.
  - Next edge: state IDLE; Busy_out=0, Done_out=0, D_out=0, Bor_out=0, Ovf_out=0.
  - Shift registers, bit counter and borrow flop cleared. Any operation in flight is discarded with no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Start_in=1 at edge k: latch A_in, B_in into shift registers; borrow flop <= Bor_in; counter <= 0; go to SHIFT.
  - Start_in=0: stay in IDLE.
- SHIFT (Busy_out=1), one bit per edge:
  - a = A_reg[0], b = B_reg[0], w = borrow flop.
  - d = a ^ b ^ w.
  - w' = (~a & b) | (~(a ^ b) & w).
  - d is shifted into the MSB of the result shift register; A_reg and B_reg shift right; counter increments.
  - Sign bits A[N-1] and B[N-1] are captured at start for the overflow calculation.
  - After the edge that processes bit N-1 (edge k+N): D_out <= assembled result, Bor_out <= w', Ovf_out <= (A[N-1] != B[N-1]) & (d_msb != A[N-1]); go to DONE.
- DONE (Done_out=1 for exactly this one cycle, Busy_out=0):
  - Start_in=1: accepted exactly as in IDLE, go to SHIFT. Back-to-back operations are allowed with no idle gap.
  - Otherwise go to IDLE.
- Latency and timing:
  - Start sampled at edge k; Busy_out high during cycles k+1..k+N; outputs valid and Done_out high in cycle k+N+1.
  - Throughput: one result per N+1 cycles.
- Start_in during SHIFT is ignored. Latched operands are unaffected. A_in, B_in and Bor_in may change freely after the start edge.
- D_out, Bor_out and Ovf_out change only at completion or reset. They are stable between Done pulses.
- Widths:
  - Result is modulo 2^N.
  - Bor_out equals the borrow out of the MSB, i.e. the inverse of carry-out for A + ~B + ~Bor_in.
  - Bor_in=1 subtracts one extra.
- Done_out and Busy_out are never high in the same cycle.

Test Plan:
- Reset, then A=100 (0x64), B=37 (0x25), Bor_in=0, Start pulse at edge k -> Busy_out high cycles k+1..k+8; Done_out pulse in cycle k+9 only; D_out=0x3F, Bor_out=0, Ovf_out=0.
- A=0x05, B=0x09, Bor_in=0 -> D_out=0xFC, Bor_out=1, Ovf_out=0.
- Bor_in edge case: A=0x00, B=0x00, Bor_in=1 -> D_out=0xFF, Bor_out=1, Ovf_out=0. Then A=0x80, B=0x01, Bor_in=0 -> D_out=0x7F, Bor_out=0, Ovf_out=1.
- Start ignored and back-to-back:
  - Start 0x64-0x25; pulse Start_in with A=0xFF, B=0x00 at cycle k+4 -> result still 0x3F at k+9.
  - Start asserted in the Done cycle with A=0x10, B=0x01 -> next Done 9 cycles later with D_out=0x0F.
- Reset mid-operation: RST_in=1 at cycle k+3 of a SHIFT -> next edge all outputs 0, IDLE, no Done pulse. A subsequent normal start completes correctly.
- Randomized sweep with N=4 over all 512 (A, B, Bor_in) combinations -> D_out, Bor_out and Ovf_out match the reference model (A - B - Bor_in) for every case.
